// File: rtl/fd_pair_latch_if.sv
// Bundle of fetch-side inputs, hazard controls and FD/DX-side outputs for the
// dual-issue fetch/decode pipeline latch.
interface fd_pair_latch_if;
   logic        i_if_valid;
   logic [31:0] i_if_pc;
   logic [31:0] i_if_insn0;
   logic [31:0] i_if_insn1;
   logic        i_fd_write;
   logic        i_control;
   logic        i_split;
   logic        i_flush;
   logic [31:0] o_fd_pc;
   logic [31:0] o_fd_insn0;
   logic [31:0] o_fd_insn1;
   logic        o_fd_valid0;
   logic        o_fd_valid1;
   logic [31:0] o_dx_insn0;
   logic [31:0] o_dx_insn1;
   logic        o_pc_advance;
   logic [7:0]  o_stall_cnt;

   modport master (
      output i_if_valid, i_if_pc, i_if_insn0, i_if_insn1,
      output i_fd_write, i_control, i_split, i_flush,
      input  o_fd_pc, o_fd_insn0, o_fd_insn1, o_fd_valid0, o_fd_valid1,
      input  o_dx_insn0, o_dx_insn1, o_pc_advance, o_stall_cnt
   );

   modport slave (
      input  i_if_valid, i_if_pc, i_if_insn0, i_if_insn1,
      input  i_fd_write, i_control, i_split, i_flush,
      output o_fd_pc, o_fd_insn0, o_fd_insn1, o_fd_valid0, o_fd_valid1,
      output o_dx_insn0, o_dx_insn1, o_pc_advance, o_stall_cnt
   );
endinterface

// File: rtl/fd_pair_latch.sv
// Fetch/decode pipeline latch for an instruction pair, with split-issue replay
// of the younger instruction, hold/flush handling and a saturating stall counter.
//
// state    | meaning
// ST_EMPTY | no valid instruction latched
// ST_PAIR  | both slots valid (older in slot 0, younger in slot 1)
// ST_YOUNG | replayed younger instruction alone in slot 0
module fd_pair_latch #(
   parameter logic [31:0] NOP = 32'h00000000
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   fd_pair_latch_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PAIR  = 2'd1,
      ST_YOUNG = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_insn0;
   logic [31:0] w_insn0_nxt;
   logic [31:0] r_insn1;
   logic [31:0] w_insn1_nxt;
   logic        r_valid0;
   logic        w_valid0_nxt;
   logic        r_valid1;
   logic        w_valid1_nxt;
   logic [7:0]  r_stall_cnt;
   logic [7:0]  w_stall_cnt_nxt;
   logic        w_split_acc;
   logic        w_stall_evt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_EMPTY;
         r_pc        <= 32'h00000000;
         r_insn0     <= NOP;
         r_insn1     <= NOP;
         r_valid0    <= 1'b0;
         r_valid1    <= 1'b0;
         r_stall_cnt <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_insn0     <= w_insn0_nxt;
         r_insn1     <= w_insn1_nxt;
         r_valid0    <= w_valid0_nxt;
         r_valid1    <= w_valid1_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   // Split only means something while a younger instruction is actually present.
   assign w_split_acc = (r_state == ST_PAIR) && bus.i_split;
   assign w_stall_evt = !bus.i_fd_write || bus.i_control;

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_insn0_nxt     = r_insn0;
      w_insn1_nxt     = r_insn1;
      w_valid0_nxt    = r_valid0;
      w_valid1_nxt    = r_valid1;
      w_stall_cnt_nxt = r_stall_cnt;

      if (w_stall_evt && (r_stall_cnt != 8'hFF)) begin
         w_stall_cnt_nxt = r_stall_cnt + 8'd1;
      end

      if (bus.i_flush) begin
         w_state_nxt  = ST_EMPTY;
         w_insn0_nxt  = NOP;
         w_insn1_nxt  = NOP;
         w_valid0_nxt = 1'b0;
         w_valid1_nxt = 1'b0;
      end else if (!bus.i_fd_write) begin
         w_state_nxt = r_state;
      end else if (w_split_acc) begin
         w_state_nxt  = ST_YOUNG;
         w_pc_nxt     = r_pc + 32'd1;
         w_insn0_nxt  = r_insn1;
         w_insn1_nxt  = NOP;
         w_valid0_nxt = 1'b1;
         w_valid1_nxt = 1'b0;
      end else if (bus.i_if_valid) begin
         w_state_nxt  = ST_PAIR;
         w_pc_nxt     = bus.i_if_pc;
         w_insn0_nxt  = bus.i_if_insn0;
         w_insn1_nxt  = bus.i_if_insn1;
         w_valid0_nxt = 1'b1;
         w_valid1_nxt = 1'b1;
      end else begin
         w_state_nxt  = ST_EMPTY;
         w_insn0_nxt  = NOP;
         w_insn1_nxt  = NOP;
         w_valid0_nxt = 1'b0;
         w_valid1_nxt = 1'b0;
      end
   end

   assign bus.o_fd_pc     = r_pc;
   assign bus.o_fd_insn0  = r_insn0;
   assign bus.o_fd_insn1  = r_insn1;
   assign bus.o_fd_valid0 = r_valid0;
   assign bus.o_fd_valid1 = r_valid1;
   assign bus.o_stall_cnt = r_stall_cnt;

   assign bus.o_dx_insn0 = (r_valid0 && !bus.i_control) ? r_insn0 : NOP;
   assign bus.o_dx_insn1 = (r_valid1 && !bus.i_control && !w_split_acc) ? r_insn1 : NOP;

   // Reset gating keeps fetch frozen while the latch is held in reset.
   assign bus.o_pc_advance = i_rst_n && !bus.i_flush && bus.i_fd_write &&
                             !w_split_acc && bus.i_if_valid;

endmodule

// File: tb/tb_fd_pair_latch.sv
// Directed bench for fd_pair_latch: load, split/replay, hold, flush priority,
// counter saturation, PC wrap and asynchronous reset.
module tb_fd_pair_latch;
   localparam logic [31:0] NOP = 32'h00000000;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fd_pair_latch_if bus ();

   fd_pair_latch #(.NOP(NOP)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_if_valid = 1'b1;
      bus.i_if_pc    = 32'h10;
      bus.i_if_insn0 = 32'hA;
      bus.i_if_insn1 = 32'hB;
      bus.i_fd_write = 1'b1;
      bus.i_control  = 1'b0;
      bus.i_split    = 1'b0;
      bus.i_flush    = 1'b0;
      #3;
      chk("rst_fd_pc", bus.o_fd_pc, 32'h0);
      chk("rst_insn0", bus.o_fd_insn0, NOP);
      chk("rst_valid0", {31'd0, bus.o_fd_valid0}, 32'd0);
      chk("rst_valid1", {31'd0, bus.o_fd_valid1}, 32'd0);
      chk("rst_stall", {24'd0, bus.o_stall_cnt}, 32'd0);
      chk("rst_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
      chk("rst_dx0", bus.o_dx_insn0, NOP);
      chk("rst_dx1", bus.o_dx_insn1, NOP);

      // Release reset between edges; first load happens on the next edge.
      tick();
      rst_n = 1'b1;
      #1;
      chk("load_pc_adv", {31'd0, bus.o_pc_advance}, 32'd1);
      tick();
      chk("load_fd_pc", bus.o_fd_pc, 32'h10);
      chk("load_insn0", bus.o_fd_insn0, 32'hA);
      chk("load_insn1", bus.o_fd_insn1, 32'hB);
      chk("load_valids", {30'd0, bus.o_fd_valid0, bus.o_fd_valid1}, 32'd3);
      chk("load_dx0", bus.o_dx_insn0, 32'hA);
      chk("load_dx1", bus.o_dx_insn1, 32'hB);

      // Split in PAIR: older issues alone, younger replays next cycle.
      bus.i_split    = 1'b1;
      bus.i_if_pc    = 32'h12;
      bus.i_if_insn0 = 32'hC;
      bus.i_if_insn1 = 32'hD;
      #1;
      chk("split_dx0", bus.o_dx_insn0, 32'hA);
      chk("split_dx1", bus.o_dx_insn1, NOP);
      chk("split_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
      tick();
      chk("young_insn0", bus.o_fd_insn0, 32'hB);
      chk("young_fd_pc", bus.o_fd_pc, 32'h11);
      chk("young_valid1", {31'd0, bus.o_fd_valid1}, 32'd0);
      chk("young_valid0", {31'd0, bus.o_fd_valid0}, 32'd1);
      chk("young_dx1", bus.o_dx_insn1, NOP);

      // In YOUNG split is ignored: fetch advances and the next pair loads.
      chk("young_pc_adv", {31'd0, bus.o_pc_advance}, 32'd1);
      chk("young_dx0", bus.o_dx_insn0, 32'hB);
      tick();
      chk("reload_fd_pc", bus.o_fd_pc, 32'h12);
      chk("reload_insn1", bus.o_fd_insn1, 32'hD);
      chk("reload_valids", {30'd0, bus.o_fd_valid0, bus.o_fd_valid1}, 32'd3);

      // Hold with nop-insert for three cycles.
      bus.i_split    = 1'b0;
      bus.i_fd_write = 1'b0;
      bus.i_control  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_dx0", bus.o_dx_insn0, NOP);
         chk("hold_dx1", bus.o_dx_insn1, NOP);
         chk("hold_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
         tick();
      end
      chk("hold_fd_pc", bus.o_fd_pc, 32'h12);
      chk("hold_insn0", bus.o_fd_insn0, 32'hC);
      chk("hold_insn1", bus.o_fd_insn1, 32'hD);
      chk("hold_stall", {24'd0, bus.o_stall_cnt}, 32'd3);

      // No fetch available: latch empties.
      bus.i_fd_write = 1'b1;
      bus.i_control  = 1'b0;
      bus.i_if_valid = 1'b0;
      #1;
      chk("empty_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
      tick();
      chk("empty_valids", {30'd0, bus.o_fd_valid0, bus.o_fd_valid1}, 32'd0);
      chk("empty_dx0", bus.o_dx_insn0, NOP);
      chk("empty_stall", {24'd0, bus.o_stall_cnt}, 32'd3);

      bus.i_if_valid = 1'b1;
      bus.i_if_pc    = 32'h20;
      bus.i_if_insn0 = 32'hE;
      bus.i_if_insn1 = 32'hF;
      tick();
      chk("pair2_insn0", bus.o_fd_insn0, 32'hE);

      // Flush beats both hold and split.
      bus.i_flush    = 1'b1;
      bus.i_fd_write = 1'b0;
      bus.i_split    = 1'b1;
      #1;
      chk("flush_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
      tick();
      chk("flush_valids", {30'd0, bus.o_fd_valid0, bus.o_fd_valid1}, 32'd0);
      chk("flush_insn0", bus.o_fd_insn0, NOP);
      chk("flush_dx0", bus.o_dx_insn0, NOP);
      chk("flush_dx1", bus.o_dx_insn1, NOP);
      chk("flush_stall", {24'd0, bus.o_stall_cnt}, 32'd4);

      // Long hold saturates the stall counter.
      bus.i_flush = 1'b0;
      bus.i_split = 1'b0;
      repeat (300) tick();
      chk("sat_stall", {24'd0, bus.o_stall_cnt}, 32'hFF);

      // PC wrap across the split increment.
      bus.i_fd_write = 1'b1;
      bus.i_if_pc    = 32'hFFFFFFFF;
      bus.i_if_insn0 = 32'h1;
      bus.i_if_insn1 = 32'h2;
      tick();
      chk("wrap_load_pc", bus.o_fd_pc, 32'hFFFFFFFF);
      bus.i_split = 1'b1;
      tick();
      chk("wrap_fd_pc", bus.o_fd_pc, 32'h00000000);
      chk("wrap_insn0", bus.o_fd_insn0, 32'h2);
      chk("wrap_stall", {24'd0, bus.o_stall_cnt}, 32'hFF);

      // Asynchronous reset while in YOUNG, between edges.
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_fd_pc", bus.o_fd_pc, 32'h0);
      chk("arst_insn0", bus.o_fd_insn0, NOP);
      chk("arst_valid0", {31'd0, bus.o_fd_valid0}, 32'd0);
      chk("arst_stall", {24'd0, bus.o_stall_cnt}, 32'd0);
      chk("arst_pc_adv", {31'd0, bus.o_pc_advance}, 32'd0);
      chk("arst_dx0", bus.o_dx_insn0, NOP);
      tick();
      chk("arst_hold_valid0", {31'd0, bus.o_fd_valid0}, 32'd0);

      bus.i_split    = 1'b0;
      bus.i_if_pc    = 32'h40;
      bus.i_if_insn0 = 32'h5;
      bus.i_if_insn1 = 32'h6;
      rst_n = 1'b1;
      tick();
      chk("post_rst_fd_pc", bus.o_fd_pc, 32'h40);
      chk("post_rst_insn1", bus.o_fd_insn1, 32'h6);
      chk("post_rst_valids", {30'd0, bus.o_fd_valid0, bus.o_fd_valid1}, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fd_pair_latch.md
FD_PAIR_LATCH -- requirements
Module: fd_pair_latch

Interface
REQ-001 Parameter: NOP, 32'h00000000, encoding driven into any invalid or squashed slot.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_valid  input  1  fetch presents an instruction pair this cycle.
REQ-005 if_pc  input  32  PC of older fetched instruction; younger is if_pc+1.
REQ-006 if_insn0 / if_insn1  input  32 each  older / younger fetched instruction.
REQ-007 fd_write  input  1  hazard-unit FDWrite; 0 = hold FD contents.
REQ-008 control  input  1  hazard-unit nop-insert; 1 = both DX-bound slots forced to NOP.
REQ-009 split  input  1  younger depends on older; issue older only, replay younger.
REQ-010 flush  input  1  taken branch/jump resolved; squash FD contents.
REQ-011 fd_pc  output  32  PC of current slot-0 instruction.
REQ-012 fd_insn0 / fd_insn1  output  32 each  FD-latched instructions, to decode and hazard compare.
REQ-013 fd_valid0 / fd_valid1  output  1 each  slot-valid flags.
REQ-014 dx_insn0 / dx_insn1  output  32 each  instructions forwarded to DX this cycle, NOP-gated.
REQ-015 pc_advance  output  1  fetch may advance PC by 2 this cycle.
REQ-016 stall_cnt  output  8  saturating count of hold/nop-insert cycles since reset.

Function
REQ-017 State machine states: EMPTY, PAIR (both slots valid), YOUNG (replayed younger alone in slot 0).
REQ-018 Priority per cycle: flush > fd_write=0 > state YOUNG > split > normal load.
REQ-019 flush=1: next state EMPTY, both valid flags cleared, insns NOP, regardless of fd_write or split.
REQ-020 fd_write=0 (no flush): all FD registers and state hold; pc_advance=0.
REQ-021 EMPTY/PAIR with fd_write=1, split=0, if_valid=1: load pair, both valid, state PAIR, pc_advance=1.
REQ-022 EMPTY/PAIR with fd_write=1, split=0, if_valid=0: state EMPTY, valids cleared, pc_advance=0.
REQ-023 PAIR with fd_write=1, split=1: fd_insn1 moves to slot 0, fd_pc increments by 1, slot 1 invalid/NOP, state YOUNG, pc_advance=0.
REQ-024 split is ignored in EMPTY and YOUNG states (no younger instruction present).
REQ-025 YOUNG with fd_write=1: load next fetch pair per REQ-021/022; pc_advance=if_valid.
REQ-026 dx_insn0 = fd_insn0 when fd_valid0 and control=0, else NOP.
REQ-027 dx_insn1 = fd_insn1 when fd_valid1, control=0 and not (split and state PAIR), else NOP.
REQ-028 dx_* outputs are combinational from FD registers and control; zero-cycle latency FD->DX.
REQ-029 pc_advance is combinational; never 1 while fd_write=0, flush=1, or split accepted.
REQ-030 stall_cnt increments by 1 on each edge where fd_write=0 or control=1; saturates at 8'hFF; flush does not clear it.
REQ-031 fd_pc arithmetic is 32-bit modulo; 32'hFFFFFFFF+1 wraps to 0.

Reset
REQ-032 reset low: immediately (asynchronously) state EMPTY, fd_pc=0, fd_insn0/1=NOP, fd_valid0/1=0, stall_cnt=0.
REQ-033 While reset low: pc_advance=0, dx_insn0/1=NOP; first load occurs on first rising edge with reset high.
REQ-034 Reset asserted mid-YOUNG or mid-hold discards pending younger replay without completing it.

Verification
REQ-035 Load: reset release, if_valid=1, if_pc=0x10, insns 0xA/0xB, fd_write=1 -> next cycle fd_pc=0x10, fd_insn0=0xA, fd_insn1=0xB, both valid, dx_insn0/1=0xA/0xB.
REQ-036 Split: in PAIR (0xA,0xB @0x10) assert split -> dx_insn1=NOP that cycle, pc_advance=0; next cycle fd_insn0=0xB, fd_pc=0x11, fd_valid1=0, state YOUNG.
REQ-037 Hold+nop: fd_write=0, control=1 for 3 cycles -> FD unchanged, dx_insn0/1=NOP, pc_advance=0, stall_cnt=3.
REQ-038 Flush wins: flush=1 with fd_write=0 and split=1 in PAIR -> next cycle state EMPTY, valids 0, dx outputs NOP.
REQ-039 Saturation/wrap: hold 300 cycles -> stall_cnt=0xFF; load if_pc=0xFFFFFFFF then split -> fd_pc=0x00000000.
REQ-040 Async reset: drop reset between edges while in YOUNG -> outputs reach reset values before next edge.
